hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning architectural register count; register 0 is hardwired zero.
REQ-002 SHALL have parameter LOAD_USE_LAT, default 1, meaning cycles until a load result is forwardable to EX.
REQ-003 SHALL have parameter ALU_BR_LAT, default 2, meaning cycles until an ALU result is visible to a branch in ID (no forwarding).
REQ-004 SHALL have parameter LOAD_BR_LAT, default 3, meaning cycles until a load result is visible to a branch in ID.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port id_valid  input  1  meaning the ID stage holds a valid instruction.
REQ-007 SHALL have ports id_rs, id_rt  input  RW=clog2(NUM_REGS)  meaning source register indices.
REQ-008 SHALL have ports id_rs_used, id_rt_used  input  1  meaning the corresponding source is actually read.
REQ-009 SHALL have port id_is_branch  input  1  meaning the ID instruction is a branch and reads its sources in ID.
REQ-010 SHALL have ports id_writes  input  1, id_is_load  input  1, id_rd  input  RW  meaning destination write, load flag, and destination index.
REQ-011 SHALL have port flush  input  1  meaning the ID instruction is squashed this cycle.
REQ-012 SHALL have port stall  output  1  meaning hold PC and IF/ID and inject a bubble into EX.
REQ-013 SHALL have port busy  output  NUM_REGS  meaning bit r set while the register-r branch countdown is nonzero.
REQ-014 SHALL have port stall_cycles  output  16  meaning saturating count of stalled cycles.

Function
REQ-015 SHALL keep two per-register countdowns, ex_cnt[r] and br_cnt[r], each wide enough for max(LOAD_USE_LAT, LOAD_BR_LAT, ALU_BR_LAT).
REQ-016 SHALL define a source as hazardous when it is used, its index is nonzero, and, for a non-branch instruction, ex_cnt > 0, or, for a branch instruction, br_cnt > 0.
REQ-017 SHALL compute stall combinationally as id_valid & !flush & (rs hazardous | rt hazardous), with zero-cycle latency.
REQ-018 SHALL issue when id_valid & !flush & !stall; on issue with id_writes and id_rd != 0, it SHALL load ex_cnt[rd] with LOAD_USE_LAT if id_is_load, else 0.
REQ-019 SHALL, on the same issue, load br_cnt[rd] with LOAD_BR_LAT if id_is_load, else ALU_BR_LAT.
REQ-020 SHALL decrement every nonzero countdown by 1 each cycle, whether or not the pipeline is stalled; counters never wrap below 0.
REQ-021 SHALL give issue priority over decrement when both affect the same register in the same cycle (newest producer wins).
REQ-022 SHALL treat a source that equals the destination of the issuing instruction as checked against the pre-issue countdown values.
REQ-023 SHALL NOT clear the countdowns on flush (older in-flight producers still complete); a flushed instruction SHALL NOT issue.
REQ-024 SHALL increment stall_cycles on each cycle where stall=1, saturating at 16'hFFFF.
REQ-025 SHALL never let a write to register 0 set any countdown.

Reset
REQ-026 SHALL, while rst=1 (asynchronously), clear all ex_cnt, br_cnt, and stall_cycles, which makes busy=0 and stall=0.
REQ-027 SHALL, when reset is asserted mid-stall, deassert stall immediately, with no stale hazards after release.

Structure
REQ-028 SHALL place NUM_REGS, the latency defaults, and the countdown width constant in the shared cpu package.
REQ-029 SHALL instantiate a sub-module sb_entry per register, holding the two countdowns with load/decrement logic; hazard compare and stall counter SHALL live in the top module.

Verification
REQ-030 SHALL cover: LW R3 issue, then ADD R4,R3,R5 next cycle -> stall=1 for exactly 1 cycle, then issue.
REQ-031 SHALL cover: ADD R3 issue, then BEQ using R3 -> stall 2 cycles; LW R3, then BEQ R3 -> stall 3 cycles; stall_cycles advances by 2 and 3 respectively.
REQ-032 SHALL cover: ADD R3 then SUB R6,R3,R2 -> no stall; a source of R0 with a pending write to R0 attempted -> no stall, busy[0]=0.
REQ-033 SHALL cover: LW R3 then a consumer with flush=1 -> stall=0 and no issue; the next unflushed consumer of R3 still sees the remaining br_cnt.
REQ-034 SHALL cover: rst asserted while stall=1 with busy=16'h0008 -> stall=0, busy=0, and stall_cycles=0 asynchronously.
REQ-035 SHALL cover: forced 70000 stall cycles -> stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default register count,
// producer-to-consumer latencies and the countdown width helper.
package hazard_scoreboard_pkg;

  localparam int NUM_REGS_DEF     = 16;
  localparam int LOAD_USE_LAT_DEF = 1;
  localparam int ALU_BR_LAT_DEF   = 2;
  localparam int LOAD_BR_LAT_DEF  = 3;

  // Bits needed to hold the largest of three latencies (at least 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(LOAD_USE_LAT_DEF, LOAD_BR_LAT_DEF, ALU_BR_LAT_DEF);

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: the EX-forwarding and ID-branch countdowns of a
// single architectural register.
//   clk, rst          : clock, asynchronous active-high reset
//   load              : newest producer of this register issues this cycle
//   ex_init, br_init  : countdown values written on load
//   ex_cnt, br_cnt    : current countdown values
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] ex_init,
  input  logic [CNT_W-1:0] br_init,
  output logic [CNT_W-1:0] ex_cnt,
  output logic [CNT_W-1:0] br_cnt
);

  // A load always wins over the decrement so the newest producer's
  // latency is what consumers see.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_cnt <= '0;
      br_cnt <= '0;
    end else if (load) begin
      ex_cnt <= ex_init;
      br_cnt <= br_init;
    end else begin
      if (ex_cnt != '0) ex_cnt <= ex_cnt - CNT_W'(1);
      if (br_cnt != '0) br_cnt <= br_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for the ID stage. Tracks, per register, how
// many cycles remain until a pending result is usable by an EX consumer
// (forwarding) and by a branch resolving in ID (no forwarding), and raises
// a combinational stall when the ID instruction would read too early.
//   clk, rst            : clock, asynchronous active-high reset
//   id_valid            : ID holds a valid instruction
//   id_rs, id_rt        : source indices; id_rs_used/id_rt_used qualify them
//   id_is_branch        : sources are read in ID (checked against br countdown)
//   id_writes, id_is_load, id_rd : destination description
//   flush               : ID instruction is squashed this cycle
//   stall               : hold PC and IF/ID, bubble into EX
//   busy                : bit r set while register r's branch countdown is nonzero
//   stall_cycles        : saturating count of stalled cycles
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int LOAD_USE_LAT = LOAD_USE_LAT_DEF,
  parameter int ALU_BR_LAT   = ALU_BR_LAT_DEF,
  parameter int LOAD_BR_LAT  = LOAD_BR_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs,
  input  logic [$clog2(NUM_REGS)-1:0] id_rt,
  input  logic                        id_rs_used,
  input  logic                        id_rt_used,
  input  logic                        id_is_branch,
  input  logic                        id_writes,
  input  logic                        id_is_load,
  input  logic [$clog2(NUM_REGS)-1:0] id_rd,
  input  logic                        flush,
  output logic                        stall,
  output logic [NUM_REGS-1:0]         busy,
  output logic [15:0]                 stall_cycles
);

  localparam int RW    = $clog2(NUM_REGS);
  localparam int CNT_W = cnt_width(LOAD_USE_LAT, LOAD_BR_LAT, ALU_BR_LAT);

  logic [CNT_W-1:0] ex_cnt [NUM_REGS];
  logic [CNT_W-1:0] br_cnt [NUM_REGS];
  logic [CNT_W-1:0] ex_init;
  logic [CNT_W-1:0] br_init;
  logic [CNT_W-1:0] rs_cnt;
  logic [CNT_W-1:0] rt_cnt;
  logic             rs_haz;
  logic             rt_haz;
  logic             issue;
  logic             wr_en;

  assign ex_init = id_is_load ? CNT_W'(LOAD_USE_LAT) : '0;
  assign br_init = id_is_load ? CNT_W'(LOAD_BR_LAT)  : CNT_W'(ALU_BR_LAT);

  // Writes to register 0 never reach an entry, so R0 can never be busy.
  assign issue = id_valid & ~flush & ~stall;
  assign wr_en = issue & id_writes & (id_rd != '0);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk     (clk),
      .rst     (rst),
      .load    (wr_en && (id_rd == RW'(r))),
      .ex_init (ex_init),
      .br_init (br_init),
      .ex_cnt  (ex_cnt[r]),
      .br_cnt  (br_cnt[r])
    );
    assign busy[r] = (br_cnt[r] != '0);
  end

  // Sources are compared against the registered (pre-issue) countdowns, so
  // an instruction reading its own destination sees the older producer.
  always_comb begin
    rs_cnt = id_is_branch ? br_cnt[id_rs] : ex_cnt[id_rs];
    rt_cnt = id_is_branch ? br_cnt[id_rt] : ex_cnt[id_rt];
    rs_haz = id_rs_used && (id_rs != '0) && (rs_cnt != '0);
    rt_haz = id_rt_used && (id_rt != '0) && (rt_cnt != '0);
    stall  = id_valid && !flush && (rs_haz || rt_haz);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
